// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor.
// The operand is split into NBLK = WIDTH/BLOCK blocks. Stage 1 resolves block 0
// and precomputes both carry-in candidates for every other block; each later
// stage picks one more block using the carry out of the block below it.
// Candidate storage shrinks by one block per stage, since resolved blocks no
// longer need their carry-in-1 alternative.
module pipelined_carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;

    // One block-wide add with explicit carry-in; returns {carry, sum}.
    function automatic logic [BLOCK:0] blk_add(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, ci};
    endfunction

    // Signed overflow: like-signed operands producing a result of the other sign.
    function automatic logic ovf_flag(input logic am, input logic bm, input logic sm);
        return (am == bm) && (sm != am);
    endfunction

    logic             stall;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [NBLK-1:0]  vld;     // vld[k-1] is the valid bit of stage k
    logic [NBLK:0]    vchain;  // vchain[k-1] feeds stage k; top bit is out_valid
    logic [WIDTH-1:0] s0_in;   // block 0 resolved, upper blocks with carry-in 0
    logic [NBLK-1:0]  k0_in;   // matching block carries

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign bx        = sub ? ~b : b;
    assign c0        = sub ? 1'b1 : cin;
    assign vchain    = {vld, in_valid};
    assign out_valid = vchain[NBLK];

    // Valid bits shift together with the data; bubbles travel as zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (!stall) begin
            vld <= vchain[NBLK-1:0];
        end
    end

    // Carry-in-0 sums for every block, except block 0 which uses the real carry-in.
    always_comb begin
        s0_in = '0;
        k0_in = '0;
        for (int j = 0; j < NBLK; j++) begin
            {k0_in[j], s0_in[j*BLOCK +: BLOCK]} =
                blk_add(a[j*BLOCK +: BLOCK], bx[j*BLOCK +: BLOCK], (j == 0) ? c0 : 1'b0);
        end
    end

    // ---- candidate pipe: carry-in-1 sums and both carries of unresolved blocks ----
    for (genvar k = 1; k < NBLK; k++) begin : cp
        logic [WIDTH-k*BLOCK-1:0] hi1_p;  // carry-in-1 sums of blocks k..NBLK-1
        logic [NBLK-k-1:0]        k0_p;   // carry-in-0 carries of blocks k..NBLK-1
        logic [NBLK-k-1:0]        k1_p;   // carry-in-1 carries of blocks k..NBLK-1

        if (k == 1) begin : head
            logic [WIDTH-BLOCK-1:0] hi1_n;
            logic [NBLK-2:0]        k1_n;

            // Carry-in-1 candidates for blocks 1..NBLK-1.
            always_comb begin
                hi1_n = '0;
                k1_n  = '0;
                for (int j = 1; j < NBLK; j++) begin
                    {k1_n[j-1], hi1_n[(j-1)*BLOCK +: BLOCK]} =
                        blk_add(a[j*BLOCK +: BLOCK], bx[j*BLOCK +: BLOCK], 1'b1);
                end
            end

            // Capture candidates on accept.
            always_ff @(posedge clk) begin
                if (vchain[0] && !stall) begin
                    hi1_p <= hi1_n;
                    k0_p  <= k0_in[NBLK-1:1];
                    k1_p  <= k1_n;
                end
            end
        end else begin : body
            // Drop the block resolved at this stage, forward the rest unchanged.
            always_ff @(posedge clk) begin
                if (vchain[k-1] && !stall) begin
                    hi1_p <= cp[k-1].hi1_p[WIDTH-(k-1)*BLOCK-1:BLOCK];
                    k0_p  <= cp[k-1].k0_p[NBLK-k:1];
                    k1_p  <= cp[k-1].k1_p[NBLK-k:1];
                end
            end
        end
    end

    // ---- resolved pipe: stage k holds blocks 0..k-1 resolved, rest as carry-in-0 ----
    for (genvar k = 1; k <= NBLK; k++) begin : rp
        logic [WIDTH-1:0] dat_p, dat_n;
        logic             cry_p, cry_n;   // carry out of block k-1
        logic             amsb_p, amsb_n;
        logic             bmsb_p, bmsb_n;

        if (k == 1) begin : head
            assign dat_n  = s0_in;
            assign cry_n  = k0_in[0];
            assign amsb_n = a[WIDTH-1];
            assign bmsb_n = bx[WIDTH-1];
        end else begin : body
            logic sel;
            assign sel = rp[k-1].cry_p;

            // Swap in the carry-in-1 sum of block k-1 when the carry below is set.
            always_comb begin
                dat_n = rp[k-1].dat_p;
                if (sel) begin
                    dat_n[(k-1)*BLOCK +: BLOCK] = cp[k-1].hi1_p[BLOCK-1:0];
                end
            end

            assign cry_n  = cp[k-1].k0_p[0] | (cp[k-1].k1_p[0] & sel);
            assign amsb_n = rp[k-1].amsb_p;
            assign bmsb_n = rp[k-1].bmsb_p;
        end

        // Advance with a valid beat; only the output stage is cleared by reset.
        always_ff @(posedge clk) begin
            if (!rst_n && (k == NBLK)) begin
                dat_p  <= '0;
                cry_p  <= 1'b0;
                amsb_p <= 1'b0;
                bmsb_p <= 1'b0;
            end else if (vchain[k-1] && !stall) begin
                dat_p  <= dat_n;
                cry_p  <= cry_n;
                amsb_p <= amsb_n;
                bmsb_p <= bmsb_n;
            end
        end
    end

    assign sum  = rp[NBLK].dat_p;
    assign cout = rp[NBLK].cry_p;
    assign ovf  = ovf_flag(rp[NBLK].amsb_p, rp[NBLK].bmsb_p, rp[NBLK].dat_p[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder: three instances (32/8, 8/4, 16/16)
// checked every cycle against an arithmetic reference with a queue-based
// latency/backpressure model.
module tb_pipelined_carry_select_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          stamp;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   started = 1'b0;

    logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic ordy0 = 1'b1, ordy1 = 1'b1, ordy2 = 1'b1;
    logic ci0 = 1'b0, ci1 = 1'b0, ci2 = 1'b0;
    logic sb0 = 1'b0, sb1 = 1'b0, sb2 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic [15:0] a2 = '0, b2 = '0;

    logic ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [15:0] s2;

    int nvec = 0;
    int nmis = 0;

    beat_t       q[3][$];
    int          adv[3]    = '{0, 0, 0};
    logic [31:0] last_s[3] = '{32'd0, 32'd0, 32'd0};
    logic        last_c[3] = '{1'b0, 1'b0, 1'b0};
    logic        last_o[3] = '{1'b0, 1'b0, 1'b0};
    string       nm[3]     = '{"u32", "u8", "u16"};
    int          npop0 = 0;
    logic [33:0] got0[$];

    always #5 clk = ~clk;

    pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(ci0), .sub(sb0), .out_valid(ov0), .out_ready(ordy0), .sum(s0),
        .cout(co0), .ovf(of0));

    pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(ordy1), .sum(s1),
        .cout(co1), .ovf(of1));

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .cin(ci2), .sub(sb2), .out_valid(ov2), .out_ready(ordy2), .sum(s2),
        .cout(co2), .ovf(of2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Reference: {cout,sum} = a + bx + c0 modulo 2^w; overflow from the sign rule.
    function automatic beat_t ref_beat(input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic sb, input int w);
        beat_t r;
        longint unsigned mask, bx, t;
        logic am, bm, sm;
        mask = (64'd1 << w) - 64'd1;
        bx   = sb ? (~64'(b)) & mask : 64'(b);
        t    = 64'(a) + bx + (sb ? 64'd1 : 64'(ci));
        r.s  = 32'(t & mask);
        r.c  = ((t >> w) & 64'd1) != 64'd0;
        am   = a[w-1];
        bm   = bx[w-1];
        sm   = r.s[w-1];
        r.o  = (am == bm) && (sm != am);
        r.stamp = 0;
        return r;
    endfunction

    // Per-cycle check of one instance, then advance its model across the coming edge.
    // A beat sits at the output once it has seen nb advancing edges since acceptance.
    task automatic mon(input int id, input int w, input int nb,
                       input logic iv, input logic ordy,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb,
                       input logic ir, input logic ov,
                       input logic [31:0] s, input logic co, input logic of);
        logic  exp_ov, stall;
        beat_t bt;
        exp_ov = (q[id].size() > 0) && ((adv[id] - q[id][0].stamp) == nb);
        stall  = exp_ov && !ordy;
        chk({nm[id], ".out_valid"}, 64'(ov), 64'(exp_ov));
        chk({nm[id], ".in_ready"},  64'(ir), 64'(!stall));
        chk({nm[id], ".sum"},       64'(s),  64'(last_s[id]));
        chk({nm[id], ".cout"},      64'(co), 64'(last_c[id]));
        chk({nm[id], ".ovf"},       64'(of), 64'(last_o[id]));
        if (!rst_n) begin
            q[id].delete();
            last_s[id] = '0;
            last_c[id] = 1'b0;
            last_o[id] = 1'b0;
        end else if (!stall) begin
            if (exp_ov) begin
                if (id == 0) begin
                    got0.push_back({of, co, s});
                    npop0++;
                end
                void'(q[id].pop_front());
            end
            if (iv) begin
                bt = ref_beat(a, b, ci, sb, w);
                bt.stamp = adv[id];
                q[id].push_back(bt);
            end
            adv[id]++;
            if ((q[id].size() > 0) && ((adv[id] - q[id][0].stamp) == nb)) begin
                last_s[id] = q[id][0].s;
                last_c[id] = q[id][0].c;
                last_o[id] = q[id][0].o;
            end
        end
    endtask

    initial begin
        @(posedge clk);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            mon(0, 32, 4, iv0, ordy0, a0, b0, ci0, sb0, ir0, ov0, s0, co0, of0);
            mon(1, 8, 2, iv1, ordy1, {24'd0, a1}, {24'd0, b1}, ci1, sb1, ir1, ov1,
                {24'd0, s1}, co1, of1);
            mon(2, 16, 1, iv2, ordy2, {16'd0, a2}, {16'd0, b2}, ci2, sb2, ir2, ov2,
                {16'd0, s2}, co2, of2);
        end
    end

    // Drive one beat on the 32-bit instance and hold it until accepted.
    task automatic send0(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb);
        int n;
        n   = 0;
        a0  = a;
        b0  = b;
        ci0 = ci;
        sb0 = sb;
        iv0 = 1'b1;
        @(negedge clk);
        while (!ir0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send0.timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [33:0] dexp[6];
        logic [31:0] e;
        int base, np;

        // Reset held three cycles with a beat offered.
        iv0 = 1'b1;
        a0  = $urandom;
        b0  = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        iv0   = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 64'(ir0), 64'd1);
        idle(1);

        // Directed add/subtract corner cases.
        dexp[0] = {1'b0, 1'b1, 32'h0000_0000};
        dexp[1] = {1'b1, 1'b0, 32'h8000_0000};
        dexp[2] = {1'b0, 1'b0, 32'h0000_0100};
        dexp[3] = {1'b0, 1'b0, 32'hFFFF_FFFE};
        dexp[4] = {1'b1, 1'b1, 32'h7FFF_FFFF};
        dexp[5] = {1'b0, 1'b1, 32'h0000_0002};
        base = got0.size();
        send0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send0(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
        send0(32'd5, 32'd7, 1'b0, 1'b1);
        send0(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        send0(32'd7, 32'd5, 1'b1, 1'b1);
        idle(8);
        chk("dir.count", 64'(got0.size() - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < got0.size()) chk($sformatf("dir.%0d", i), 64'(got0[base+i]), 64'(dexp[i]));
        end

        // Back-to-back stream with a three-cycle output stall in the middle.
        base = got0.size();
        fork
            begin
                for (int i = 1; i <= 8; i++) send0(32'(i), 32'(i) * 32'h0101_0101, 1'b0, 1'b0);
            end
            begin
                idle(5);
                ordy0 = 1'b0;
                idle(3);
                ordy0 = 1'b1;
            end
        join
        idle(8);
        chk("bp.count", 64'(got0.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            e = 32'(i + 1) * 32'h0101_0102;
            if (base + i < got0.size()) chk($sformatf("bp.%0d", i), 64'(got0[base+i]), {30'd0, 2'b00, e});
        end

        // Reset with four beats in flight: none of them may surface.
        ordy0 = 1'b0;
        for (int i = 0; i < 4; i++) send0($urandom, $urandom, 1'b0, 1'b0);
        np    = npop0;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        ordy0 = 1'b1;
        @(negedge clk);
        chk("rstmid.out_valid", 64'(ov0), 64'd0);
        idle(8);
        chk("rstmid.pops", 64'(npop0 - np), 64'd0);

        // Random traffic on all instances; exhaustive a/b sweep on the 8-bit one.
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    iv0   = ($urandom_range(3) != 0);
                    ordy0 = ($urandom_range(2) != 0);
                    a0    = $urandom;
                    b0    = ($urandom_range(7) == 0) ? ~a0 : $urandom;
                    ci0   = 1'($urandom_range(1));
                    sb0   = 1'($urandom_range(1));
                    idle(1);
                end
                iv0   = 1'b0;
                ordy0 = 1'b1;
            end
            begin
                logic [15:0] v;
                iv1 = 1'b1;
                for (int i = 0; i < 65536; i++) begin
                    v   = 16'(i);
                    a1  = v[15:8];
                    b1  = v[7:0];
                    ci1 = v[0] ^ v[8];
                    sb1 = v[1] ^ v[9];
                    idle(1);
                end
                iv1 = 1'b0;
            end
            begin
                for (int i = 0; i < 3000; i++) begin
                    iv2   = ($urandom_range(3) != 0);
                    ordy2 = ($urandom_range(3) != 0);
                    a2    = 16'($urandom);
                    b2    = ($urandom_range(7) == 0) ? ~a2 : 16'($urandom);
                    ci2   = 1'($urandom_range(1));
                    sb2   = 1'($urandom_range(1));
                    idle(1);
                end
                iv2   = 1'b0;
                ordy2 = 1'b1;
            end
        join

        idle(10);
        chk("u32.drain", 64'(q[0].size()), 64'd0);
        chk("u8.drain",  64'(q[1].size()), 64'd0);
        chk("u16.drain", 64'(q[2].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
